// File: rtl/card_dealer.sv
// card_dealer: deals pseudo-random ranks 1..13 from a finite shoe of NUM_DECKS decks.
// A free-running rank counter picks the starting rank; exhausted ranks are skipped upward.
module card_dealer #(
  parameter int unsigned NUM_DECKS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       deal_req,
  input  logic       reshuffle,
  output logic [3:0] card_out,
  output logic       card_valid,
  output logic [8:0] cards_left,
  output logic       shoe_empty
);

  localparam logic [8:0] FullShoe = 9'(52 * NUM_DECKS);
  localparam logic [5:0] PerRank  = 6'(4 * NUM_DECKS);

  typedef enum logic [0:0] {StIdle, StSearch} state_e;

  state_e     state_q, state_d;
  logic [3:0] rank_ctr_q;
  logic [3:0] cand_q;
  logic [5:0] cnt_q [13];
  logic [8:0] cards_left_q;
  logic [3:0] card_out_q;
  logic       card_valid_q;

  logic       do_reshuffle, do_start, do_take, do_skip;
  logic [3:0] cand_idx;
  logic       cand_hit;

  // cand is always 1..13, so the 0-based slot index stays inside the table
  assign cand_idx   = cand_q - 4'd1;
  assign cand_hit   = (cnt_q[cand_idx] != '0);
  assign shoe_empty = (cards_left_q == '0);
  assign cards_left = cards_left_q;
  assign card_out   = card_out_q;
  assign card_valid = card_valid_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state: reshuffle wins over a deal request; an empty shoe ignores requests
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (!reshuffle && deal_req && !shoe_empty) state_d = StSearch;
      StSearch: if (cand_hit) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Control decode per state
  always_comb begin
    do_reshuffle = 1'b0;
    do_start     = 1'b0;
    do_take      = 1'b0;
    do_skip      = 1'b0;
    unique case (state_q)
      StIdle: begin
        do_reshuffle = reshuffle;
        do_start     = !reshuffle && deal_req && !shoe_empty;
      end
      StSearch: begin
        do_take = cand_hit;
        do_skip = !cand_hit;
      end
      default: ;
    endcase
  end

  // Rank counter runs in every state; candidate walks upward past exhausted ranks
  always_ff @(posedge clk) begin
    if (reset) begin
      rank_ctr_q <= 4'd1;
      cand_q     <= 4'd1;
    end else begin
      rank_ctr_q <= (rank_ctr_q == 4'd13) ? 4'd1 : rank_ctr_q + 4'd1;
      if (do_start)     cand_q <= rank_ctr_q;
      else if (do_skip) cand_q <= (cand_q == 4'd13) ? 4'd1 : cand_q + 4'd1;
    end
  end

  // Per-rank counts and total remaining
  always_ff @(posedge clk) begin
    if (reset || do_reshuffle) begin
      for (int r = 0; r < 13; r++) cnt_q[r] <= PerRank;
      cards_left_q <= FullShoe;
    end else if (do_take) begin
      cnt_q[cand_idx] <= cnt_q[cand_idx] - 6'd1;
      cards_left_q    <= cards_left_q - 9'd1;
    end
  end

  // Dealt card and its one-cycle valid strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      card_out_q   <= '0;
      card_valid_q <= 1'b0;
    end else begin
      card_valid_q <= do_take;
      if (do_take) card_out_q <= cand_q;
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer: directed stimulus with a scoreboard queue checked by a separate monitor.
module tb_card_dealer;

  logic       clk = 1'b0;
  logic       reset, deal_req, reshuffle;
  logic [3:0] card_out;
  logic       card_valid;
  logic [8:0] cards_left;
  logic       shoe_empty;

  card_dealer #(.NUM_DECKS(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .deal_req   (deal_req),
    .reshuffle  (reshuffle),
    .card_out   (card_out),
    .card_valid (card_valid),
    .cards_left (cards_left),
    .shoe_empty (shoe_empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int exp_rank = 1;

  // Edge count and expected free-running rank counter
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    exp_rank <= reset ? 1 : ((exp_rank == 13) ? 1 : exp_rank + 1);
  end

  typedef struct {
    int card;
    int left;
    int at_cyc;
  } exp_t;

  exp_t sbq[$];
  int   mcnt [1:13];
  int   mleft;
  int   tally [1:13];
  int   last_card;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic model_full();
    for (int r = 1; r <= 13; r++) mcnt[r] = 4;
    mleft = 52;
  endtask

  // Called just after an edge while IDLE with deal_req being driven high for the next edge
  task automatic model_deal(output int k);
    exp_t e;
    int   r;
    r = exp_rank;
    k = 0;
    while (mcnt[r] == 0 && k < 13) begin
      r = (r == 13) ? 1 : r + 1;
      k++;
    end
    mcnt[r]--;
    mleft--;
    last_card = r;
    e.card   = r;
    e.left   = mleft;
    e.at_cyc = cyc + 2 + k;
    sbq.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_rank(input int r);
    for (int i = 0; i < 14; i++) begin
      if (exp_rank == r) break;
      tick(1);
    end
  endtask

  task automatic pulse_deal_at(input int r);
    int k;
    tick(3);
    wait_rank(r);
    deal_req = 1'b1;
    model_deal(k);
    tick(1);
    deal_req = 1'b0;
    tick(k + 2);
  endtask

  // Monitor: every valid pulse must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (card_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = sbq.pop_front();
        check("card_out", int'(card_out), e.card);
        check("cards_left", int'(cards_left), e.left);
        check("shoe_empty", int'(shoe_empty), int'(e.left == 0));
        check("valid_cycle", cyc, e.at_cyc);
        if (card_out >= 4'd1 && card_out <= 4'd13) tally[int'(card_out)]++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b1;
    deal_req = 1'b0;
    reshuffle = 1'b0;
    model_full();
    for (int r = 1; r <= 13; r++) tally[r] = 0;
    tick(1);

    // Reset values and rank counter sequence
    check("rst_card_out", int'(card_out), 0);
    check("rst_card_valid", int'(card_valid), 0);
    check("rst_cards_left", int'(cards_left), 52);
    check("rst_shoe_empty", int'(shoe_empty), 0);
    reset = 1'b0;
    for (int i = 0; i < 14; i++) begin
      check("rank_ctr", int'(dut.rank_ctr_q), (i % 13) + 1);
      tick(1);
    end

    // Single deal at rank 5
    pulse_deal_at(5);
    check("cnt5", int'(dut.cnt_q[4]), 3);

    // Exhaust ranks 7 and 8, then a request at 7 skips to 9
    for (int i = 0; i < 4; i++) pulse_deal_at(7);
    for (int i = 0; i < 4; i++) pulse_deal_at(8);
    pulse_deal_at(7);
    check("cnt9", int'(dut.cnt_q[8]), 3);
    check("cards_left_42", int'(cards_left), 42);

    // Reset in the cycle after entering SEARCH aborts the deal
    tick(3);
    wait_rank(3);
    deal_req = 1'b1;
    tick(1);
    deal_req = 1'b0;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    model_full();
    for (int r = 1; r <= 13; r++) tally[r] = 0;
    check("abort_cards_left", int'(cards_left), 52);
    check("abort_card_out", int'(card_out), 0);
    check("abort_card_valid", int'(card_valid), 0);
    tick(4);

    // Drain the whole shoe with deal_req held high
    deal_req = 1'b1;
    for (int n = 0; n < 52; n++) begin
      model_deal(k);
      tick(k + 2);
    end
    tick(20);
    for (int r = 1; r <= 13; r++) check("rank_tally", tally[r], 4);
    check("empty_card_out_held", int'(card_out), last_card);
    check("empty_cards_left", int'(cards_left), 0);
    check("empty_flag", int'(shoe_empty), 1);

    // Reshuffle wins over a simultaneous request; next request deals normally
    reshuffle = 1'b1;
    tick(1);
    reshuffle = 1'b0;
    model_full();
    check("reshuffle_cards_left", int'(cards_left), 52);
    check("reshuffle_empty", int'(shoe_empty), 0);
    model_deal(k);
    tick(1);
    deal_req = 1'b0;
    tick(16);

    check("scoreboard_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
